// File: rtl/display_timing_gen.sv
// Raster timing generator: walks the H/V raster, requests pixels from the
// renderer and re-aligns sync/enable with the renderer's colour.
module display_timing_gen #(
    parameter int       RGB_W    = 12,
    parameter int       H_ACTIVE = 640,
    parameter int       H_FP     = 16,
    parameter int       H_SYNC   = 96,
    parameter int       H_BP     = 48,
    parameter int       V_ACTIVE = 480,
    parameter int       V_FP     = 10,
    parameter int       V_SYNC   = 2,
    parameter int       V_BP     = 33,
    parameter bit       HS_POL   = 1'b0,
    parameter bit       VS_POL   = 1'b0,
    parameter int       LATENCY  = 2,
    localparam int      H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int      V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int      X_W      = $clog2(H_TOTAL),
    localparam int      Y_W      = $clog2(V_TOTAL)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_en_i,
    output logic [X_W-1:0]   x_o,
    output logic [Y_W-1:0]   y_o,
    output logic             req_o,
    output logic             frame_start_o,
    input  logic [RGB_W-1:0] rgb_i,
    output logic [RGB_W-1:0] vga_rgb_o,
    output logic             vga_hs_o,
    output logic             vga_vs_o,
    output logic             de_o
);

    if (LATENCY < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_err
        $error("display_timing_gen: LATENCY, porch and sync terms must be >= 1");
    end

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] h_q, h_d;
    logic [Y_W-1:0] v_q, v_d;

    logic req_raw;
    logic hs_raw;
    logic vs_raw;

    logic [LATENCY-1:0] req_dl_q, req_dl_d;
    logic [LATENCY-1:0] hs_dl_q, hs_dl_d;
    logic [LATENCY-1:0] vs_dl_q, vs_dl_d;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    // Raster counters
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign req_raw = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw  = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_raw  = (v_q >= VS_START) && (v_q < VS_END);

    assign x_o           = h_q;
    assign y_o           = v_q;
    assign req_o         = req_raw;
    assign frame_start_o = pix_en_i && (h_q == '0) && (v_q == '0);

    // Delay line matching the renderer latency; index LATENCY-1 is the tail
    always_comb begin
        req_dl_d = req_dl_q;
        hs_dl_d  = hs_dl_q;
        vs_dl_d  = vs_dl_q;
        if (pix_en_i) begin
            req_dl_d[0] = req_raw;
            hs_dl_d[0]  = hs_raw;
            vs_dl_d[0]  = vs_raw;
            for (int i = 1; i < LATENCY; i++) begin
                req_dl_d[i] = req_dl_q[i-1];
                hs_dl_d[i]  = hs_dl_q[i-1];
                vs_dl_d[i]  = vs_dl_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_dl_q <= '0;
            hs_dl_q  <= '0;
            vs_dl_q  <= '0;
        end else begin
            req_dl_q <= req_dl_d;
            hs_dl_q  <= hs_dl_d;
            vs_dl_q  <= vs_dl_d;
        end
    end

    // Output register stage
    always_comb begin
        rgb_d = rgb_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en_i) begin
            de_d  = req_dl_q[LATENCY-1];
            rgb_d = req_dl_q[LATENCY-1] ? rgb_i : '0;
            hs_d  = hs_dl_q[LATENCY-1] ? HS_POL : ~HS_POL;
            vs_d  = vs_dl_q[LATENCY-1] ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign vga_rgb_o = rgb_q;
    assign de_o      = de_q;
    assign vga_hs_o  = hs_q;
    assign vga_vs_o  = vs_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Self-checking bench for display_timing_gen on a 16x8 raster, LATENCY 2.
// Reference model is expressed in strobes-since-reset arithmetic.
module tb_display_timing_gen;

    localparam int HT  = 16;
    localparam int VT  = 8;
    localparam int FT  = HT * VT;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [11:0] rgb_in;
    logic [3:0]  x;
    logic [2:0]  y;
    logic        req;
    logic        fs;
    logic [11:0] vrgb;
    logic        hs;
    logic        vs;
    logic        de;

    int n = 0;
    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    display_timing_gen #(
        .RGB_W(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LATENCY(LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en),
        .x_o(x), .y_o(y), .req_o(req), .frame_start_o(fs),
        .rgb_i(rgb_in), .vga_rgb_o(vrgb), .vga_hs_o(hs),
        .vga_vs_o(vs), .de_o(de)
    );

    function automatic int ex(int k); return (k % FT) % HT; endfunction
    function automatic int ey(int k); return (k % FT) / HT; endfunction
    function automatic bit e_req(int k); return ex(k) < 8 && ey(k) < 4; endfunction
    function automatic logic [11:0] pid(int k);
        return 12'(12'hA00 + ey(k) * 16 + ex(k));
    endfunction
    // Outputs after k strobes show pixel k-LAT-1 (nothing before that).
    function automatic bit o_de(int k);
        return k > LAT && e_req(k - LAT - 1);
    endfunction
    function automatic bit o_hs(int k);
        return !(k > LAT && ex(k - LAT - 1) >= 10 && ex(k - LAT - 1) < 13);
    endfunction
    function automatic bit o_vs(int k);
        return !(k > LAT && ey(k - LAT - 1) >= 5 && ey(k - LAT - 1) < 7);
    endfunction
    function automatic logic [11:0] o_rgb(int k);
        return o_de(k) ? pid(k - LAT - 1) : 12'h000;
    endfunction

    task automatic drive(input bit en, input bit rst);
        rst_n  = !rst;
        pix_en = en;
        rgb_in = (en && n >= LAT) ? pid(n - LAT) : 12'($urandom);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) n = 0;
        else if (pix_en) n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 1); adv();
        drive(0, 1); adv();
        drive(1, 1); adv();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0);
            if (i == 0) begin
                nchk++; if (x !== 4'd0) begin nfail++; $display("FAIL reset_x got %0d want 0", x); end
                nchk++; if (y !== 3'd0) begin nfail++; $display("FAIL reset_y got %0d want 0", y); end
                nchk++; if (req !== 1'b1) begin nfail++; $display("FAIL reset_req got %b want 1", req); end
                nchk++; if (fs !== 1'b1) begin nfail++; $display("FAIL reset_fs got %b want 1", fs); end
                nchk++; if (vrgb !== 12'h0) begin nfail++; $display("FAIL reset_rgb got %h want 0", vrgb); end
            end
            nchk++; if (de !== 1'b0) begin nfail++; $display("FAIL reset_de c%0d got %b want 0", i, de); end
            nchk++; if (hs !== 1'b1) begin nfail++; $display("FAIL reset_hs c%0d got %b want 1", i, hs); end
            nchk++; if (vs !== 1'b1) begin nfail++; $display("FAIL reset_vs c%0d got %b want 1", i, vs); end
            adv();
        end
    endtask

    task automatic test_line();
        int t = 0, t_x10 = -1, t_fall0 = -1, t_fall1 = -1, lows = 0;
        bit prev_hs = 1'b1;
        while (ex(n) != 0) begin drive(1, 0); adv(); end
        for (int i = 0; i < 2 * HT; i++) begin
            drive(1, 0);
            nchk++; if (x !== 4'(ex(n))) begin nfail++; $display("FAIL line_x n=%0d got %0d want %0d", n, x, ex(n)); end
            nchk++; if (req !== e_req(n)) begin nfail++; $display("FAIL line_req n=%0d got %b want %b", n, req, e_req(n)); end
            nchk++; if (hs !== o_hs(n)) begin nfail++; $display("FAIL line_hs n=%0d got %b want %b", n, hs, o_hs(n)); end
            if (i < HT && ex(n) == 10) t_x10 = t;
            if (i < HT && hs === 1'b0) lows++;
            if (prev_hs === 1'b1 && hs === 1'b0) begin
                if (t_fall0 < 0) t_fall0 = t; else if (t_fall1 < 0) t_fall1 = t;
            end
            prev_hs = hs;
            t++;
            adv();
        end
        nchk++; if (lows != 3) begin nfail++; $display("FAIL hs_width got %0d want 3", lows); end
        nchk++; if (t_fall0 - t_x10 != 3) begin nfail++; $display("FAIL hs_delay got %0d want 3", t_fall0 - t_x10); end
        nchk++; if (t_fall1 - t_fall0 != HT) begin nfail++; $display("FAIL line_period got %0d want %0d", t_fall1 - t_fall0, HT); end
    endtask

    task automatic test_frames();
        int fs_cnt = 0, wraps = 0, vs_low[2] = '{0, 0};
        int prev_y = -1;
        while (n % FT != 0) begin drive(1, 0); adv(); end
        for (int i = 0; i < 2 * FT; i++) begin
            drive(1, 0);
            nchk++; if (y !== 3'(ey(n))) begin nfail++; $display("FAIL frame_y n=%0d got %0d want %0d", n, y, ey(n)); end
            nchk++; if (de !== o_de(n)) begin nfail++; $display("FAIL frame_de n=%0d got %b want %b", n, de, o_de(n)); end
            nchk++; if (vrgb !== o_rgb(n)) begin nfail++; $display("FAIL frame_rgb n=%0d got %h want %h", n, vrgb, o_rgb(n)); end
            nchk++; if (vs !== o_vs(n)) begin nfail++; $display("FAIL frame_vs n=%0d got %b want %b", n, vs, o_vs(n)); end
            if (fs === 1'b1) fs_cnt++;
            if (vs === 1'b0) vs_low[i / FT]++;
            if (prev_y == 7 && y === 3'd0) wraps++;
            prev_y = int'(y);
            adv();
        end
        nchk++; if (fs_cnt != 2) begin nfail++; $display("FAIL fs_pulses got %0d want 2", fs_cnt); end
        nchk++; if (wraps != 1) begin nfail++; $display("FAIL y_wrap got %0d want 1", wraps); end
        for (int f = 0; f < 2; f++) begin
            nchk++; if (vs_low[f] != 32) begin nfail++; $display("FAIL vs_width f%0d got %0d want 32", f, vs_low[f]); end
        end
    endtask

    // mode 0: strobe every 3rd cycle; mode 1: random strobes
    task automatic test_strobe(input int mode, input int cycles);
        bit en, last_en = 1'b1;
        logic [11:0] p_rgb = '0;
        logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            en = (mode == 0) ? (i % 3 == 2) : 1'($urandom_range(0, 1));
            drive(en, 0);
            nchk++; if (x !== 4'(ex(n)) || y !== 3'(ey(n))) begin nfail++; $display("FAIL strobe_xy m%0d n=%0d got %0d,%0d want %0d,%0d", mode, n, x, y, ex(n), ey(n)); end
            nchk++; if (req !== e_req(n)) begin nfail++; $display("FAIL strobe_req m%0d n=%0d got %b want %b", mode, n, req, e_req(n)); end
            nchk++; if (fs !== (en && n % FT == 0)) begin nfail++; $display("FAIL strobe_fs m%0d n=%0d got %b", mode, n, fs); end
            nchk++; if (de !== o_de(n) || hs !== o_hs(n) || vs !== o_vs(n)) begin nfail++; $display("FAIL strobe_ctl m%0d n=%0d got %b%b%b want %b%b%b", mode, n, de, hs, vs, o_de(n), o_hs(n), o_vs(n)); end
            nchk++; if (vrgb !== o_rgb(n)) begin nfail++; $display("FAIL strobe_rgb m%0d n=%0d got %h want %h", mode, n, vrgb, o_rgb(n)); end
            if (!last_en) begin
                nchk++; if (vrgb !== p_rgb || de !== p_de || hs !== p_hs || vs !== p_vs) begin nfail++; $display("FAIL strobe_hold m%0d n=%0d rgb %h was %h", mode, n, vrgb, p_rgb); end
            end
            p_rgb = vrgb; p_de = de; p_hs = hs; p_vs = vs;
            last_en = en;
            adv();
        end
    endtask

    task automatic test_midframe_reset();
        while (!(ex(n) == 5 && ey(n) == 2)) begin drive(1, 0); adv(); end
        drive(1, 1); adv();
        drive(1, 0);
        nchk++; if (x !== 4'd0 || y !== 3'd0) begin nfail++; $display("FAIL mrst_xy got %0d,%0d want 0,0", x, y); end
        nchk++; if (req !== 1'b1 || fs !== 1'b1) begin nfail++; $display("FAIL mrst_req_fs got %b%b want 11", req, fs); end
        nchk++; if (de !== 1'b0 || vrgb !== 12'h0) begin nfail++; $display("FAIL mrst_de_rgb got %b %h want 0 0", de, vrgb); end
        nchk++; if (hs !== 1'b1 || vs !== 1'b1) begin nfail++; $display("FAIL mrst_sync got %b%b want 11", hs, vs); end
        for (int i = 0; i < 3 * FT; i++) begin
            nchk++; if (de !== o_de(n) || vrgb !== o_rgb(n) || hs !== o_hs(n) || vs !== o_vs(n)) begin nfail++; $display("FAIL mrst_run n=%0d got %b %h %b%b", n, de, vrgb, hs, vs); end
            adv();
            drive(1, 0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        rgb_in = '0;
        @(negedge clk);
        test_reset();
        test_line();
        test_frames();
        test_strobe(0, 3 * FT + 30);
        test_strobe(1, 400);
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
